// File: rtl/riscv_fetch_stage.sv
// Instruction fetch stage: owns the PC, issues word-aligned fetches under a
// credit limit, buffers returned instructions in order and hands them to
// decode. A redirect flushes the buffer and discards all stale responses.
module riscv_fetch_stage #(
  parameter int unsigned           ADDR_WIDTH   = 32,
  parameter int unsigned           XLEN         = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int unsigned           FIFO_DEPTH   = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  fetch_en_i,
  input  logic                  redirect_valid_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  output logic                  imem_req_valid_o,
  input  logic                  imem_req_ready_i,
  output logic [ADDR_WIDTH-1:0] imem_req_addr_o,
  input  logic                  imem_rsp_valid_i,
  input  logic [XLEN-1:0]       imem_rsp_data_i,
  input  logic                  imem_rsp_error_i,
  output logic                  if_valid_o,
  input  logic                  if_ready_i,
  output logic [XLEN-1:0]       if_instr_o,
  output logic [ADDR_WIDTH-1:0] if_pc_o,
  output logic                  if_fault_o
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] CAP = (CW+1)'(FIFO_DEPTH);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [CW-1:0]         out_cnt;
  logic [CW-1:0]         drop_cnt;
  logic [CW-1:0]         fifo_cnt;

  logic [ADDR_WIDTH-1:0] pcq [FIFO_DEPTH];
  logic [PW-1:0]         pcq_wr;
  logic [PW-1:0]         pcq_rd;

  logic [XLEN-1:0]       buf_instr [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] buf_pc    [FIFO_DEPTH];
  logic                  buf_fault [FIFO_DEPTH];
  logic [PW-1:0]         buf_wr;
  logic [PW-1:0]         buf_rd;

  logic                  req_fire;
  logic                  rsp_keep;
  logic                  if_fire;
  logic                  rsp_drop;

  // Credit check uses registered counts only, so valid cannot fall while a
  // request is waiting for ready (the sum never grows without a handshake).
  assign imem_req_valid_o = (state == S_RUN)
                         && (({1'b0, out_cnt} + {1'b0, fifo_cnt}) < CAP)
                         && !redirect_valid_i;
  assign imem_req_addr_o  = pc;
  assign req_fire         = imem_req_valid_o && imem_req_ready_i;
  assign rsp_drop         = imem_rsp_valid_i && (drop_cnt != '0);
  assign rsp_keep         = imem_rsp_valid_i && (drop_cnt == '0) && !redirect_valid_i;

  assign if_valid_o = (fifo_cnt != '0);
  assign if_fire    = if_valid_o && if_ready_i && !redirect_valid_i;
  assign if_instr_o = if_valid_o ? buf_instr[buf_rd] : '0;
  assign if_pc_o    = if_valid_o ? buf_pc[buf_rd]    : '0;
  assign if_fault_o = if_valid_o ? buf_fault[buf_rd] : 1'b0;

  // Run/idle control: leave RUN only once no request is left hanging.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (fetch_en_i) state <= S_RUN;
        S_RUN:  if (!fetch_en_i && (!imem_req_valid_o || imem_req_ready_i)) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // PC, credit counters and queue pointers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc       <= RESET_VECTOR;
      out_cnt  <= '0;
      drop_cnt <= '0;
      fifo_cnt <= '0;
      pcq_wr   <= '0;
      pcq_rd   <= '0;
      buf_wr   <= '0;
      buf_rd   <= '0;
    end else begin
      out_cnt <= out_cnt + CW'(req_fire) - CW'(imem_rsp_valid_i);
      if (req_fire)         pcq_wr <= pcq_wr + PW'(1);
      if (imem_rsp_valid_i) pcq_rd <= pcq_rd + PW'(1);

      if (redirect_valid_i) begin
        pc       <= redirect_pc_i & ~(ADDR_WIDTH'(3));
        // Everything still outstanding after this cycle belongs to the old path.
        drop_cnt <= out_cnt - CW'(imem_rsp_valid_i);
        fifo_cnt <= '0;
        buf_wr   <= '0;
        buf_rd   <= '0;
      end else begin
        if (req_fire) pc <= pc + ADDR_WIDTH'(4);
        if (rsp_drop) drop_cnt <= drop_cnt - CW'(1);
        fifo_cnt <= fifo_cnt + CW'(rsp_keep) - CW'(if_fire);
        if (rsp_keep) buf_wr <= buf_wr + PW'(1);
        if (if_fire)  buf_rd <= buf_rd + PW'(1);
      end
    end
  end

  // Storage for request PCs and buffered instructions.
  always_ff @(posedge clk_i) begin
    if (req_fire) pcq[pcq_wr] <= pc;
    if (rsp_keep) begin
      buf_instr[buf_wr] <= imem_rsp_data_i;
      buf_pc[buf_wr]    <= pcq[pcq_rd];
      buf_fault[buf_wr] <= imem_rsp_error_i;
    end
  end

endmodule
